signal_merge: RTL
=================

// Module: signal_merge
// PURPOSE
// - Inverse of the ADC channel splitter: joins two independent per-channel AXI-Stream sample
//   streams (32-bit signed, sign-extended) into one packed stream of two ADC_DATA_WIDTH fields.
// - Sits in front of the DAC path / DMA writer; CH1 goes to the low field, CH2 to the high field.
// - Each channel is buffered independently. One packed word is emitted per matched sample pair.
// - Full AXIS backpressure on all three ports.
// PARAMETERS
// - ADC_DATA_WIDTH    16  width of each packed sample field.
// - AXIS_TDATA_WIDTH  32  width of all tdata buses; must equal 2*ADC_DATA_WIDTH.
// - FIFO_DEPTH         4  entries per channel buffer; power of two, >=2.
// PORTS
// - aclk                 in   1     clock; all ports are synchronous to its rising edge
// - aresetn              in   1     asynchronous active-low reset
// - S_AXIS_PORT1_tdata   in   AXIS  CH1 sample, signed
// - S_AXIS_PORT1_tvalid  in   1     CH1 valid
// - S_AXIS_PORT1_tready  out  1     CH1 ready (CH1 FIFO not full)
// - S_AXIS_PORT2_tdata   in   AXIS  CH2 sample, signed
// - S_AXIS_PORT2_tvalid  in   1     CH2 valid
// - S_AXIS_PORT2_tready  out  1     CH2 ready (CH2 FIFO not full)
// - M_AXIS_tdata         out  AXIS  packed word: {CH2[ADC-1:0], CH1[ADC-1:0]}
// - M_AXIS_tvalid        out  1     packed word valid
// - M_AXIS_tready        in   1     downstream ready
// BEHAVIOUR
// - Reset (async assert, sync deassert of internal state):
//   - both FIFOs empty; all pointers 0.
//   - S_*_tready=0 while aresetn=0, then 1 from the first clock after deassertion.
//   - M_AXIS_tvalid=0; M_AXIS_tdata=0.
//   - Reset mid-operation discards all buffered and output data; no partial word is emitted.
// - Input accept: a beat is written to its channel FIFO on an edge where tvalid&tready=1.
//   - tready depends only on FIFO fill (registered count), never on tvalid.
//   - The two channels are fully independent; either may run ahead by up to FIFO_DEPTH samples.
// - Pairing: the output register loads on an edge where both FIFOs are non-empty and
//   (!M_AXIS_tvalid || M_AXIS_tready). Both FIFO heads pop on that same edge.
// - Simultaneous push and pop on a full FIFO: the pop frees space only on the next cycle.
//   tready stays 0 in the cycle where the FIFO is full.
// - Simultaneous push and pop on a non-full FIFO: count is unchanged; data order is preserved.
// - Latency: a pair pushed into empty FIFOs on edge k gives M_AXIS_tvalid=1 after edge k+1.
// - Throughput: 1 word/cycle sustained when both inputs stream and M_AXIS_tready=1.
// - Output hold: while M_AXIS_tvalid=1 and M_AXIS_tready=0, tdata/tvalid are stable.
// - Pointers wrap modulo FIFO_DEPTH; an extra MSB distinguishes full from empty.
// - Field conversion (default build): truncate, field = sample[ADC_DATA_WIDTH-1:0].
// - No state machine beyond the FIFO counts and the output-register valid bit.
// CONFIGURATION
// - SIGNAL_MERGE_SAT_EN defined:
//   - each sample saturates to [-2^(ADC-1), 2^(ADC-1)-1] before packing.
//   - adds output port sat_flag (1 bit): set on any load where either channel clipped.
//   - sat_flag is cleared only by reset; its reset value is 0.
// - SIGNAL_MERGE_SAT_EN undefined: pure truncation; sat_flag port and its logic are absent.
// TESTING
// - Reset/idle: aresetn low 5 cycles, inputs active
//   -> all tready=0, M_AXIS_tvalid=0, tdata=0; tready=1 one cycle after release.
// - Basic pack: CH1=0x00000123, CH2=0xFFFFFF00, M_tready=1 -> M_tdata=0xFF000123, 2 cycles later.
// - Skew/fill: CH1 sends 4 beats, CH2 idle
//   -> CH1 tready=0 after 4th beat, no output; CH2 then sends 4 -> 4 words, in order.
// - Backpressure: both streaming, M_tready toggles 1,0,0,1 random 1000 beats
//   -> no loss/duplication vs reference model, tdata stable while stalled.
// - Reset mid-stream: assert aresetn with 3 words buffered -> tvalid=0 immediately, none emitted after.
// - SAT_EN: CH1=0x00012345, CH2=0xFFFF0000
//   -> M_tdata=0x80007FFF, sat_flag=1; without macro -> 0x00002345.

Source files
------------

// File: rtl/signal_merge.sv
// Joins two per-channel AXI-Stream sample streams into one packed word {CH2, CH1}.
// Optional macro SIGNAL_MERGE_SAT_EN: saturate samples instead of truncating and expose sat_flag.
module signal_merge #(
   parameter int ADC_DATA_WIDTH   = 16,
   parameter int AXIS_TDATA_WIDTH = 32,
   parameter int FIFO_DEPTH       = 4
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_PORT1_tdata,
   input  logic                        S_AXIS_PORT1_tvalid,
   output logic                        S_AXIS_PORT1_tready,
   input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_PORT2_tdata,
   input  logic                        S_AXIS_PORT2_tvalid,
   output logic                        S_AXIS_PORT2_tready,
   output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
   output logic                        M_AXIS_tvalid,
   input  logic                        M_AXIS_tready
`ifdef SIGNAL_MERGE_SAT_EN
   ,
   output logic                        sat_flag
`endif
);

   localparam int AW = ADC_DATA_WIDTH;
   localparam int DW = AXIS_TDATA_WIDTH;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

   // Samples are converted on the way in, so each FIFO entry is only a field (plus clip bit).
`ifdef SIGNAL_MERGE_SAT_EN
   localparam int EW = AW + 1;
`else
   localparam int EW = AW;
`endif

   function automatic logic [EW-1:0] to_entry(input logic [DW-1:0] s);
`ifdef SIGNAL_MERGE_SAT_EN
      logic fits;
      fits = (&s[DW-1:AW-1]) || !(|s[DW-1:AW-1]);
      if (fits) return {1'b0, s[AW-1:0]};
      return {1'b1, s[DW-1], {(AW-1){~s[DW-1]}}};
`else
      return s[AW-1:0];
`endif
   endfunction

`ifndef SIGNAL_MERGE_SAT_EN
   logic unused_upper;
   assign unused_upper = ^{S_AXIS_PORT1_tdata[DW-1:AW], S_AXIS_PORT2_tdata[DW-1:AW]};
`endif

   logic [EW-1:0] mem1 [FIFO_DEPTH];
   logic [EW-1:0] mem2 [FIFO_DEPTH];
   logic [PW:0]   wp1, rp1, wp2, rp2;
   logic [PW:0]   cnt1, cnt2;
   logic [EW-1:0] head1, head2;
   logic          in_rdy;
   logic          push1, push2, load;

   // A beat transfers on any rising edge with tvalid && tready; tready is a function of
   // registered FIFO fill only, and a producer holds tdata stable while tvalid && !tready.
   assign cnt1 = wp1 - rp1;
   assign cnt2 = wp2 - rp2;
   assign S_AXIS_PORT1_tready = in_rdy && (cnt1 != FULL_CNT);
   assign S_AXIS_PORT2_tready = in_rdy && (cnt2 != FULL_CNT);
   assign push1 = S_AXIS_PORT1_tvalid && S_AXIS_PORT1_tready;
   assign push2 = S_AXIS_PORT2_tvalid && S_AXIS_PORT2_tready;
   assign head1 = mem1[rp1[PW-1:0]];
   assign head2 = mem2[rp2[PW-1:0]];
   assign load  = (cnt1 != '0) && (cnt2 != '0) && (!M_AXIS_tvalid || M_AXIS_tready);

   always_ff @(posedge aclk) begin
      if (push1) mem1[wp1[PW-1:0]] <= to_entry(S_AXIS_PORT1_tdata);
      if (push2) mem2[wp2[PW-1:0]] <= to_entry(S_AXIS_PORT2_tdata);
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         in_rdy        <= 1'b0;
         wp1           <= '0;
         rp1           <= '0;
         wp2           <= '0;
         rp2           <= '0;
         M_AXIS_tvalid <= 1'b0;
         M_AXIS_tdata  <= '0;
      end else begin
         in_rdy <= 1'b1;
         if (push1) wp1 <= wp1 + 1'b1;
         if (push2) wp2 <= wp2 + 1'b1;
         if (load) begin
            rp1           <= rp1 + 1'b1;
            rp2           <= rp2 + 1'b1;
            M_AXIS_tdata  <= {head2[AW-1:0], head1[AW-1:0]};
            M_AXIS_tvalid <= 1'b1;
         end else if (M_AXIS_tready) begin
            M_AXIS_tvalid <= 1'b0;
         end
      end
   end

`ifdef SIGNAL_MERGE_SAT_EN
   // Sticky until reset: records that at least one emitted field was clipped.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         sat_flag <= 1'b0;
      end else if (load && (head1[AW] || head2[AW])) begin
         sat_flag <= 1'b1;
      end
   end
`endif

endmodule
